row_render_tex: RTL and testbench
=================================

Name: row_render_tex

Overview:
- Registered, parametrised successor to the flat-colour row renderer. Decides per pixel whether the current hpos lies inside the wall span of height `size` centred on the view.
- Steps a fixed-point texture V coordinate across that span.
- Emits a texture address and the registered texel colour (or a flat side colour).
- Sits between the tracer/reciprocal stage, which supplies per-line size/side/texu/step, and the VGA RGB mux.

Parameters:
- H_VIEW, 640, visible pixels per line; HALF = H_VIEW/2.
- SIZE_W, 11, width of size input.
- TEX_W, 6, texture coordinate bits (64x64 texels).
- FRAC_W, 10, fractional bits of the V accumulator and step.
- TEXTURED, 1, 1 = texel colour from tex_rgb; 0 = flat colour by side.
- FLAT_C0, 6'b10_00_00, flat {b,g,r} colour for side=0.
- FLAT_C1, 6'b11_00_00, flat {b,g,r} colour for side=1.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- load  in  1  pulse; latch *_in into shadow registers
- side_in  in  1  wall side for the next line
- size_in  in  SIZE_W  half-height of wall span for the next line
- texu_in  in  TEX_W  texture U column for the next line
- step_in  in  TEX_W+FRAC_W  V increment per pixel (unsigned fixed point)
- texv_init_in  in  TEX_W+FRAC_W  starting V at the first span pixel
- line_start  in  1  pulse in the cycle hpos==0
- hpos  in  10  current horizontal position; increments by 1 per clk
- visible  in  1  display-active qualifier
- tex_addr  out  1+2*TEX_W  {side, texu, texv integer part}; combinational from active registers
- tex_rgb  in  6  texel {b,g,r} for tex_addr, returned same cycle
- hit  out  1  registered: previous-cycle pixel is inside span
- r,g,b  out  2 each  registered colour; 0 when hit=0

Behaviour:
- Async reset:
  - State IDLE; shadow and active registers, accumulator, hit, r, g, b all cleared.
  - tex_addr = 0.
- Span bounds are computed from the active size:
  - size > HALF: start = 0, end = H_VIEW-1 (full line).
  - Otherwise: start = HALF-size, end = min(HALF+size, H_VIEW-1).
  - size=0 gives a single pixel at hpos=HALF.
- load writes the shadow registers. line_start copies shadow to active, sets acc = texv_init, and sets state to WAIT.
- load and line_start in the same cycle: active takes the newly loaded values (bypass).
- load alone never disturbs the line in progress.
- FSM:
  - IDLE: never hit. Exit to WAIT only on line_start.
  - WAIT: hit_c = (hpos==start). If hpos==start, go to SPAN, or to DONE if start==end.
  - SPAN: hit_c = 1. If hpos==end, go to DONE.
  - DONE: hit_c = 0. Next line_start goes to WAIT.
  - line_start overrides every state, including mid-span.
- Accumulator:
  - acc += step on every cycle where hit_c=1, wrapping modulo 2^(TEX_W+FRAC_W), so textures tile.
  - The first span pixel uses texv_init.
  - Advances regardless of visible.
- tex_addr = {side, texu, acc[TEX_W+FRAC_W-1:FRAC_W]}.
- Output stage, registered with 1-cycle latency:
  - hit <= hit_c & visible.
  - {b,g,r} <= hit_c & visible ? (TEXTURED ? tex_rgb : (side ? FLAT_C1 : FLAT_C0)) : 0.
- visible=0 blanks the output only; FSM and accumulator still progress.
- Reset mid-span: outputs go to 0 immediately (async). No hit occurs until load + line_start.

Test Plan:
- Reset held, then released with no line_start; sweep hpos 0..639 -> hit=0 and rgb=0 throughout; state IDLE; tex_addr=0.
- load size=0, side=1, TEXTURED=0, then line_start -> hit=1 only in the cycle after hpos=320; {b,g,r}=6'b11_00_00 there.
- load size=100, texu=5, step=1<<FRAC_W (1.0), texv_init=0; line_start:
  - hit for hpos 220..420, observed on cycles 221..421.
  - tex_addr V field is 0,1,2,… and wraps 63->0 at hpos 284.
  - r,g,b equal the tex_rgb driven one cycle earlier.
- size=700, texv_init=10<<FRAC_W, step=0.5 -> hit for all hpos 0..639; V is 10,10,11,11,…; DONE after hpos 639.
- load and line_start in the same cycle with size=50 (previous shadow size=200) -> span 270..370.
  - A later lone load of size=10 mid-line leaves the current span unchanged.
  - The next line spans 310..330.
- Assert reset at hpos=300 inside a span -> hit, rgb=0 asynchronously.
  - After release plus line_start without load: size=0 span at 320 only, V=0.
  - Also check visible=0 over hpos 320..330 blanks output while V keeps stepping.

Source files
------------

// File: rtl/row_render_tex.sv
// rtl/row_render_tex.sv - textured wall-span row renderer with per-line shadow registers
// Steps a fixed-point V coordinate across the centred span and registers the texel colour.
module row_render_tex #(
    parameter int          H_VIEW   = 640,
    parameter int          SIZE_W   = 11,
    parameter int          TEX_W    = 6,
    parameter int          FRAC_W   = 10,
    parameter bit          TEXTURED = 1'b1,
    parameter logic [5:0]  FLAT_C0  = 6'b10_00_00,
    parameter logic [5:0]  FLAT_C1  = 6'b11_00_00
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    side_in,
    input  logic [SIZE_W-1:0]       size_in,
    input  logic [TEX_W-1:0]        texu_in,
    input  logic [TEX_W+FRAC_W-1:0] step_in,
    input  logic [TEX_W+FRAC_W-1:0] texv_init_in,
    input  logic                    line_start,
    input  logic [9:0]              hpos,
    input  logic                    visible,
    output logic [2*TEX_W:0]        tex_addr,
    input  logic [5:0]              tex_rgb,
    output logic                    hit,
    output logic [1:0]              r,
    output logic [1:0]              g,
    output logic [1:0]              b
);
    localparam int ACC_W = TEX_W + FRAC_W;
    localparam int HALF  = H_VIEW / 2;
    localparam logic [SIZE_W:0] HALF_X = (SIZE_W+1)'(HALF);
    localparam logic [SIZE_W:0] LAST_X = (SIZE_W+1)'(H_VIEW - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SPAN, S_DONE} state_t;

    state_t             r_state;
    logic               r_sh_side, r_side;
    logic [SIZE_W-1:0]  r_sh_size, r_size;
    logic [TEX_W-1:0]   r_sh_texu, r_texu;
    logic [ACC_W-1:0]   r_sh_step, r_step;
    logic [ACC_W-1:0]   r_sh_texv, r_acc;

    logic               w_ld_side, w_a_side;
    logic [SIZE_W-1:0]  w_ld_size, w_a_size;
    logic [TEX_W-1:0]   w_ld_texu, w_a_texu;
    logic [ACC_W-1:0]   w_ld_step, w_a_step, w_ld_texv, w_acc;
    logic [SIZE_W:0]    w_size_x, w_hi;
    logic [9:0]         w_start, w_end;
    state_t             w_state, w_next;
    logic               w_hit;
    logic [5:0]         w_pix;

    // A load in the same cycle as line_start is forwarded straight into the new line.
    always_comb begin
        w_ld_side = load ? side_in      : r_sh_side;
        w_ld_size = load ? size_in      : r_sh_size;
        w_ld_texu = load ? texu_in      : r_sh_texu;
        w_ld_step = load ? step_in      : r_sh_step;
        w_ld_texv = load ? texv_init_in : r_sh_texv;
        w_a_side  = line_start ? w_ld_side : r_side;
        w_a_size  = line_start ? w_ld_size : r_size;
        w_a_texu  = line_start ? w_ld_texu : r_texu;
        w_a_step  = line_start ? w_ld_step : r_step;
        w_acc     = line_start ? w_ld_texv : r_acc;
        w_state   = line_start ? S_WAIT    : r_state;
    end

    always_comb begin
        w_size_x = {1'b0, w_a_size};
        w_hi     = HALF_X + w_size_x;
        w_start  = '0;
        w_end    = 10'(H_VIEW - 1);
        if (w_size_x <= HALF_X) begin
            w_start = 10'(HALF_X - w_size_x);
            w_end   = (w_hi > LAST_X) ? 10'(H_VIEW - 1) : 10'(w_hi);
        end
    end

    always_comb begin
        w_hit  = 1'b0;
        w_next = w_state;
        case (w_state)
            S_IDLE: w_next = S_IDLE;
            S_WAIT: begin
                if (hpos == w_start) begin
                    w_hit  = 1'b1;
                    w_next = (w_start == w_end) ? S_DONE : S_SPAN;
                end
            end
            S_SPAN: begin
                w_hit = 1'b1;
                if (hpos == w_end) w_next = S_DONE;
            end
            default: w_next = S_DONE;
        endcase
    end

    assign tex_addr = {w_a_side, w_a_texu, w_acc[ACC_W-1:FRAC_W]};
    assign w_pix    = TEXTURED ? tex_rgb : (w_a_side ? FLAT_C1 : FLAT_C0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sh_side <= 1'b0;
            r_sh_size <= '0;
            r_sh_texu <= '0;
            r_sh_step <= '0;
            r_sh_texv <= '0;
            r_side    <= 1'b0;
            r_size    <= '0;
            r_texu    <= '0;
            r_step    <= '0;
            r_acc     <= '0;
            hit       <= 1'b0;
            {b, g, r} <= '0;
        end else begin
            if (load) begin
                r_sh_side <= side_in;
                r_sh_size <= size_in;
                r_sh_texu <= texu_in;
                r_sh_step <= step_in;
                r_sh_texv <= texv_init_in;
            end
            r_side    <= w_a_side;
            r_size    <= w_a_size;
            r_texu    <= w_a_texu;
            r_step    <= w_a_step;
            r_state   <= w_next;
            // Wraps modulo 2^ACC_W so the texture tiles vertically.
            r_acc     <= w_hit ? w_acc + w_a_step : w_acc;
            hit       <= w_hit & visible;
            {b, g, r} <= (w_hit & visible) ? w_pix : 6'd0;
        end
    end
endmodule

// File: tb/tb_row_render_tex.sv
// tb/tb_row_render_tex.sv - randomized bench for row_render_tex against a span/V reference model
// Runs a textured and a flat-colour instance side by side on the same stimulus.
module tb_row_render_tex;
    logic        clk = 1'b0;
    logic        reset, load, side_in, line_start, visible;
    logic [10:0] size_in;
    logic [5:0]  texu_in, tex_rgb;
    logic [15:0] step_in, texv_init_in;
    logic [9:0]  hpos;
    logic [12:0] tex_addr_t, tex_addr_f;
    logic        hit_t, hit_f;
    logic [1:0]  r_t, g_t, b_t, r_f, g_f, b_f;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_sh_side, m_sh_size, m_sh_texu, m_sh_step, m_sh_texv;
    int m_side, m_size, m_texu, m_step, m_texv, m_s, m_e;
    bit m_run;
    bit exp_hit;
    int exp_rgb, exp_flat;
    bit zero_addr;

    row_render_tex #(.TEXTURED(1'b1)) dut_t (
        .clk(clk), .reset(reset), .load(load), .side_in(side_in), .size_in(size_in),
        .texu_in(texu_in), .step_in(step_in), .texv_init_in(texv_init_in),
        .line_start(line_start), .hpos(hpos), .visible(visible), .tex_addr(tex_addr_t),
        .tex_rgb(tex_rgb), .hit(hit_t), .r(r_t), .g(g_t), .b(b_t));

    row_render_tex #(.TEXTURED(1'b0)) dut_f (
        .clk(clk), .reset(reset), .load(load), .side_in(side_in), .size_in(size_in),
        .texu_in(texu_in), .step_in(step_in), .texv_init_in(texv_init_in),
        .line_start(line_start), .hpos(hpos), .visible(visible), .tex_addr(tex_addr_f),
        .tex_rgb(tex_rgb), .hit(hit_f), .r(r_f), .g(g_f), .b(b_f));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sh_side = 0; m_sh_size = 0; m_sh_texu = 0; m_sh_step = 0; m_sh_texv = 0;
        m_side = 0; m_size = 0; m_texu = 0; m_step = 0; m_texv = 0;
        m_run = 0; exp_hit = 0; exp_rgb = 0; exp_flat = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_hit_t"}, hit_t, 0);
        chk({tag, "_rgb_t"}, {b_t, g_t, r_t}, 0);
        chk({tag, "_hit_f"}, hit_f, 0);
        chk({tag, "_rgb_f"}, {b_f, g_f, r_f}, 0);
    endtask

    // One 800-clock line; hpos 0..639 visible unless blanked. Optional loads / reset at given hpos.
    task automatic run_line(input int ld_hp, input int ld_size, input int ld_side, input int ld_texu,
                            input int ld_step, input int ld_texv, input int ld2_hp, input int ld2_size,
                            input bit ls, input int rst_hp, input int blank_lo, input int blank_hi,
                            input bit vis_rand);
        int v;
        bit in_span;
        for (int hp = 0; hp < 800; hp++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            chk("hit_t", hit_t, exp_hit);
            chk("rgb_t", {b_t, g_t, r_t}, exp_rgb);
            chk("hit_f", hit_f, exp_hit);
            chk("rgb_f", {b_f, g_f, r_f}, exp_flat);

            hpos         = 10'(hp);
            line_start   = ls && (hp == 0);
            load         = (hp == ld_hp) || (hp == ld2_hp);
            side_in      = load ? 1'(ld_side) : 1'($urandom);
            size_in      = load ? 11'((hp == ld2_hp) ? ld2_size : ld_size) : 11'($urandom);
            texu_in      = load ? 6'(ld_texu) : 6'($urandom);
            step_in      = load ? 16'(ld_step) : 16'($urandom);
            texv_init_in = load ? 16'(ld_texv) : 16'($urandom);
            visible      = (hp < 640) && !(hp >= blank_lo && hp <= blank_hi)
                           && (!vis_rand || $urandom_range(0, 3) != 0);
            tex_rgb      = 6'($urandom);

            if (load) begin
                m_sh_side = side_in; m_sh_size = size_in; m_sh_texu = texu_in;
                m_sh_step = step_in; m_sh_texv = texv_init_in;
            end
            if (line_start) begin
                m_side = m_sh_side; m_size = m_sh_size; m_texu = m_sh_texu;
                m_step = m_sh_step; m_texv = m_sh_texv; m_run = 1;
                if (m_size > 320) begin
                    m_s = 0; m_e = 639;
                end else begin
                    m_s = 320 - m_size;
                    m_e = (320 + m_size > 639) ? 639 : 320 + m_size;
                end
            end

            if (hp == rst_hp) begin
                #1 reset = 1'b1;
                #1 check_outputs_zero("async_rst");
                model_reset();
            end

            #1;
            if (zero_addr) begin
                chk("addr_idle_t", tex_addr_t, 0);
                chk("addr_idle_f", tex_addr_f, 0);
            end
            in_span = m_run && hp >= m_s && hp <= m_e;
            if (in_span) begin
                v = (m_texv + (hp - m_s) * m_step) & 16'hFFFF;
                chk("tex_addr_t", tex_addr_t, (m_side << 12) | (m_texu << 6) | (v >> 10));
                chk("tex_addr_f", tex_addr_f, (m_side << 12) | (m_texu << 6) | (v >> 10));
                if (hp == m_e) m_run = 0;
            end
            exp_hit  = in_span && visible;
            exp_rgb  = exp_hit ? int'(tex_rgb) : 0;
            exp_flat = exp_hit ? (m_side ? 6'b11_0000 : 6'b10_0000) : 0;
        end
    endtask

    initial begin
        reset = 1'b1; load = 0; side_in = 0; line_start = 0; visible = 0;
        size_in = 0; texu_in = 0; step_in = 0; texv_init_in = 0; hpos = 0; tex_rgb = 0;
        model_reset();
        zero_addr = 1;
        repeat (3) begin
            @(negedge clk);
            check_outputs_zero("in_reset");
            chk("addr_rst_t", tex_addr_t, 0);
        end
        // idle line, no line_start
        run_line(-1, 0, 0, 0, 0, 0, -1, 0, 0, -1, -1, -1, 0);
        zero_addr = 0;
        // single pixel at 320, side 1
        run_line(700, 0, 1, $urandom_range(0, 63), 1024, 0, -1, 0, 0, -1, -1, -1, 0);
        run_line(-1, 0, 0, 0, 0, 0, -1, 0, 1, -1, -1, -1, 0);
        // span 220..420, V steps by 1 and wraps at 284
        run_line(0, 100, 0, 5, 1 << 10, 0, -1, 0, 1, -1, -1, -1, 0);
        // full line, step 0.5 from V=10; lone mid-line load of size 200 must not disturb it
        run_line(0, 700, 1, 9, 512, 10 << 10, 500, 200, 1, -1, -1, -1, 0);
        // bypass load of size 50, then lone load of size 10 mid-line
        run_line(0, 50, 0, 17, 300, 0, 350, 10, 1, -1, -1, -1, 0);
        // next line picks up size 10: 310..330
        run_line(-1, 0, 0, 0, 0, 0, -1, 0, 1, -1, -1, -1, 0);
        // reset at hpos 300 inside span
        run_line(0, 100, 1, 33, 1 << 10, 0, -1, 0, 1, 300, -1, -1, 0);
        // line_start without load after reset: size 0 at 320, V 0
        run_line(-1, 0, 0, 0, 0, 0, -1, 0, 1, -1, -1, -1, 0);
        // visible low over 320..330 while V keeps stepping
        run_line(0, 100, 0, 2, $urandom_range(1, 4000), $urandom, -1, 0, 1, -1, 320, 330, 0);
        // randomized lines
        for (int i = 0; i < 4; i++)
            run_line(0, $urandom_range(0, 800), $urandom_range(0, 1), $urandom_range(0, 63),
                     $urandom_range(0, 65535), $urandom_range(0, 65535), -1, 0, 1, -1, -1, -1, 1);
        @(negedge clk);
        chk("final_hit_t", hit_t, exp_hit);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
